overlay_loader: RTL and testbench
=================================

OVERLAY_LOADER -- requirements
Module: overlay_loader

Interface
REQ-001 The module SHALL have parameter OVR_INDEX, default 8'd2, ioctl_index value that selects overlay downloads.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, number of pending word entries; power of two, minimum 2.
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
 - clk_sys  in  1  sole clock; one clock, all logic on rising edge.
 - reset_n  in  1  asynchronous, active-low reset.
 - ioctl_download  in  1  download in progress.
 - ioctl_index  in  8  download file index.
 - ioctl_wr  in  1  byte strobe, one cycle.
 - ioctl_addr  in  25  byte address.
 - ioctl_dout  in  8  byte data.
 - ioctl_wait  out  1  backpressure to the HPS.
 - mem_we  out  1  SDRAM write request, level.
 - mem_addr  out  25  SDRAM byte address, bit 0 always 0.
 - mem_din  out  16  SDRAM word {A,B,G,R}, 4 bits each.
 - mem_ack  in  1  one-cycle write-accept pulse.
 - overlay_valid  out  1  complete overlay resident in SDRAM.
 - overflow  out  1  sticky: a byte was dropped.
 - word_count  out  24  words committed since download start.

Function
REQ-004 Active download SHALL be ioctl_download==1 and ioctl_index==OVR_INDEX; ioctl_wr outside an active download SHALL be ignored.
REQ-005 The state machine SHALL have states IDLE, LOAD, FLUSH, DRAIN, DONE.
REQ-006 IDLE->LOAD SHALL occur on the rising edge of active download. On that transition: FIFO emptied, overlay_valid=0, overflow=0, word_count=0, pending-byte flag cleared.
REQ-007 In LOAD, a write with ioctl_addr[0]==0 SHALL latch the byte as the low byte and set the pending flag; a second even byte while pending SHALL replace it.
REQ-008 In LOAD, a write with ioctl_addr[0]==1 SHALL push {ioctl_addr[24:1],1'b0 ; ioctl_dout, low} into the FIFO and clear the pending flag. The low byte SHALL be the latched byte if pending with matching addr[24:1], otherwise 8'h00.
REQ-009 A push while the FIFO is full SHALL drop the word and set overflow=1.
REQ-010 ioctl_wait SHALL be 1 whenever FIFO occupancy >= FIFO_DEPTH-1, and 0 in IDLE and DONE.
REQ-011 LOAD->FLUSH SHALL occur when active download deasserts. In FLUSH, if the pending flag is set, a word {8'h00, low} at the pending address SHALL be pushed; FLUSH SHALL then go to DRAIN after one cycle.
REQ-012 DRAIN->DONE SHALL occur when the FIFO is empty and no request is outstanding. On entry to DONE, overlay_valid=1 if word_count!=0.
REQ-013 DONE->LOAD SHALL occur on a new active-download rising edge, applying the REQ-006 clearing.
REQ-014 The memory handshake SHALL drive mem_we=1 whenever the FIFO is non-empty, with mem_addr/mem_din equal to the head entry and held stable until mem_ack.
REQ-015 On mem_ack the head SHALL pop and word_count SHALL increment, saturating at 24'hFFFFFF. mem_we SHALL drop for at least one cycle after each ack, so the next request is at ack+1 or later.
REQ-016 mem_ack while mem_we==0 SHALL be ignored.
REQ-017 A push and a pop in the same cycle SHALL keep occupancy unchanged and SHALL NOT count as an overflow when the FIFO was full.
REQ-018 Write-to-request latency SHALL be 1 cycle: an odd byte written at cycle N into an empty FIFO gives mem_we=1 at N+1.
REQ-019 If the download deasserts and reasserts (new rising edge) before DONE, the FIFO SHALL be flushed and the outstanding request abandoned (mem_we=0 next cycle), then LOAD restarts.

Reset
REQ-020 reset_n=0 SHALL asynchronously force IDLE, FIFO empty, pending=0, mem_we=0, mem_addr=0, mem_din=0, ioctl_wait=0, overlay_valid=0, overflow=0, word_count=0.
REQ-021 Release SHALL be synchronised; first state change no earlier than the second clk_sys edge after reset_n rises.
REQ-022 Reset asserted mid-LOAD or mid-DRAIN SHALL abandon all pending words without issuing further mem_we.

Verification
REQ-023 Index 2, bytes 0x34@0, 0x12@1, mem_ack 2 cycles after req -> mem_we with addr 0, din 16'h1234; word_count=1; overlay_valid=1 after download end.
REQ-024 5-byte download 11,22,33,44,55 -> words 2211@0, 4433@2, 0055@4 in order; word_count=3.
REQ-025 mem_ack held off 20 cycles while 8 bytes stream -> ioctl_wait=1 at occupancy 3, no overflow, all 4 words written in address order.
REQ-026 Ignore ioctl_wait and write 12 bytes with mem_ack withheld -> overflow=1; FIFO holds exactly FIFO_DEPTH words.
REQ-027 ioctl_index=1 download -> no mem_we, state stays IDLE, overlay_valid unchanged.
REQ-028 reset_n pulsed low mid-DRAIN -> all outputs at reset values within same cycle; no mem_we after release.

Source files
------------

// File: rtl/overlay_loader.sv
// Streams overlay bytes from the HPS download port into SDRAM as 16-bit words,
// pairing even/odd bytes and buffering them in a small FIFO against SDRAM latency.
module overlay_loader #(
  parameter logic [7:0] OVR_INDEX  = 8'd2,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  output logic        overlay_valid,
  output logic        overflow,
  output logic [23:0] word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HIGH_WM = CW'(FIFO_DEPTH - 1);

  state_t        state_q, state_d;
  logic [1:0]    rst_sync_q;
  logic          run;
  logic          active_q;
  logic          pend_q, pend_d;
  logic [7:0]    low_q, low_d;
  logic [23:0]   paddr_q, paddr_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_after_pop;
  logic          mem_we_q, mem_we_d;
  logic [24:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic          wait_q, wait_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic [23:0]   wc_q, wc_d;

  logic [23:0]   fifo_addr [FIFO_DEPTH];
  logic [15:0]   fifo_data [FIFO_DEPTH];

  logic          active, rise, load_wr, even_wr, odd_push, flush_push;
  logic          push_req, push, pop, drop, full;
  logic [23:0]   push_addr, head_addr;
  logic [15:0]   push_data, head_data;

  // Reset is asserted asynchronously but released through two flops, so the
  // datapath only starts moving once the release is clean in this domain.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  assign active     = ioctl_download && (ioctl_index == OVR_INDEX);
  assign rise       = active && !active_q;
  assign load_wr    = (state_q == LOAD) && active && ioctl_wr;
  assign even_wr    = load_wr && !ioctl_addr[0];
  assign odd_push   = load_wr && ioctl_addr[0];
  assign flush_push = (state_q == FLUSH) && pend_q && !rise;
  assign full       = (cnt_q == DEPTH_C);
  assign pop        = run && mem_we_q && mem_ack && !rise;
  assign push_req   = run && (odd_push || flush_push);
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

  assign push_addr = odd_push ? ioctl_addr[24:1] : paddr_q;
  assign push_data = odd_push
                   ? {ioctl_dout, (pend_q && (paddr_q == ioctl_addr[24:1])) ? low_q : 8'h00}
                   : {8'h00, low_q};

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_q] <= push_addr;
      fifo_data[wr_q] <= push_data;
    end
  end

  always_comb begin
    cnt_after_pop = cnt_q - CW'(pop);
    cnt_d         = rise ? '0 : cnt_after_pop + CW'(push);
    rd_d          = rise ? '0 : rd_q + AW'(pop);
    wr_d          = rise ? '0 : wr_q + AW'(push);

    // A word pushed into an otherwise-empty FIFO becomes the head directly.
    if (push && (cnt_after_pop == '0)) begin
      head_addr = push_addr;
      head_data = push_data;
    end else begin
      head_addr = fifo_addr[rd_d];
      head_data = fifo_data[rd_d];
    end

    state_d = state_q;
    if (rise) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    if (!active) state_d = FLUSH;
        FLUSH:   state_d = DRAIN;
        DRAIN:   if ((cnt_q == '0) && !mem_we_q) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    pend_d  = pend_q;
    low_d   = low_q;
    paddr_d = paddr_q;
    if (rise || odd_push || (state_q == FLUSH)) begin
      pend_d = 1'b0;
    end else if (even_wr) begin
      pend_d  = 1'b1;
      low_d   = ioctl_dout;
      paddr_d = ioctl_addr[24:1];
    end

    // The request drops for a cycle after every accept so SDRAM sees a fresh edge.
    mem_we_d   = !rise && (cnt_d != '0) && !pop;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (!rise && (cnt_d != '0)) begin
      mem_addr_d = {head_addr, 1'b0};
      mem_din_d  = head_data;
    end

    wait_d = ((state_d == LOAD) || (state_d == FLUSH) || (state_d == DRAIN))
             && (cnt_d >= HIGH_WM);

    if (rise)                                    wc_d = '0;
    else if (pop && (wc_q != 24'hFFFFFF))        wc_d = wc_q + 24'd1;
    else                                         wc_d = wc_q;

    ovf_d = rise ? 1'b0 : (ovf_q || drop);

    if (rise)                                          valid_d = 1'b0;
    else if ((state_q == DRAIN) && (state_d == DONE))  valid_d = (wc_q != '0);
    else                                               valid_d = valid_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      active_q   <= 1'b0;
      pend_q     <= 1'b0;
      low_q      <= '0;
      paddr_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      wait_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      wc_q       <= '0;
    end else if (run) begin
      state_q    <= state_d;
      active_q   <= active;
      pend_q     <= pend_d;
      low_q      <= low_d;
      paddr_q    <= paddr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      wait_q     <= wait_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      wc_q       <= wc_d;
    end
  end

  assign ioctl_wait    = wait_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_din       = mem_din_q;
  assign overlay_valid = valid_q;
  assign overflow      = ovf_q;
  assign word_count    = wc_q;

endmodule

// File: tb/tb_overlay_loader.sv
// Directed bench for overlay_loader: a background SDRAM responder logs every
// accepted word, and scenario tasks compare outputs against hand-computed values.
module tb_overlay_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack = 1'b0;
  logic        overlay_valid;
  logic        overflow;
  logic [23:0] word_count;

  int total = 0;
  int bad = 0;

  logic        ack_en = 1'b0;
  int          ack_delay = 0;
  int          ack_wait = 0;
  int          we_cycles = 0;
  int          log_n = 0;
  logic [24:0] log_addr [32];
  logic [15:0] log_din [32];

  overlay_loader #(.OVR_INDEX(8'd2), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
    .overlay_valid(overlay_valid), .overflow(overflow), .word_count(word_count)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acks a request after ack_delay idle cycles and records it.
  always @(negedge clk_sys) begin
    mem_ack = 1'b0;
    if (mem_we) begin
      we_cycles = we_cycles + 1;
      if (ack_en && ack_wait >= ack_delay) begin
        mem_ack = 1'b1;
        ack_wait = 0;
        if (log_n < 32) begin
          log_addr[log_n] = mem_addr;
          log_din[log_n] = mem_din;
        end
        log_n = log_n + 1;
        $display("sdram write addr=%h din=%h", mem_addr, mem_din);
      end else begin
        ack_wait = ack_wait + 1;
      end
    end else begin
      ack_wait = 0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_index = idx;
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 25'd0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_din !== 16'd0) begin bad++; $display("FAIL reset_mem_din got=%h exp=0", mem_din); end
    total++; if ({ioctl_wait, overlay_valid, overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {ioctl_wait, overlay_valid, overflow}); end
    total++; if (word_count !== 24'd0) begin bad++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    log_n = 0; ack_en = 1'b1; ack_delay = 2;
    start_dl(8'd2);
    wr_byte(25'd0, 8'h34);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_even_no_req got=%b exp=0", mem_we); end
    wr_byte(25'd1, 8'h12);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", mem_we); end
    end_dl();
    tick(15);
    total++; if (log_n !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", log_n); end
    total++; if (log_addr[0] !== 25'd0 || log_din[0] !== 16'h1234) begin bad++; $display("FAIL single_word got=%h/%h exp=0/1234", log_addr[0], log_din[0]); end
    total++; if (word_count !== 24'd1) begin bad++; $display("FAIL single_word_count got=%0d exp=1", word_count); end
    total++; if (overlay_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", overlay_valid); end
  endtask

  task automatic test_five();
    logic [24:0] ea [3];
    logic [15:0] ed [3];
    ea = '{25'd0, 25'd2, 25'd4};
    ed = '{16'h2211, 16'h4433, 16'h0055};
    log_n = 0; ack_en = 1'b1; ack_delay = 0;
    start_dl(8'd2);
    tick(2);
    total++; if (overlay_valid !== 1'b0) begin bad++; $display("FAIL five_valid_cleared got=%b exp=0", overlay_valid); end
    total++; if (word_count !== 24'd0) begin bad++; $display("FAIL five_count_cleared got=%0d exp=0", word_count); end
    for (int i = 0; i < 5; i++) wr_byte(25'(i), 8'(8'h11 * (i + 1)));
    end_dl();
    tick(20);
    total++; if (log_n !== 3) begin bad++; $display("FAIL five_count got=%0d exp=3", log_n); end
    for (int i = 0; i < 3; i++) begin
      total++; if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin bad++; $display("FAIL five_word%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_din[i], ea[i], ed[i]); end
    end
    total++; if (word_count !== 24'd3) begin bad++; $display("FAIL five_word_count got=%0d exp=3", word_count); end
  endtask

  task automatic test_backpressure();
    log_n = 0; ack_en = 1'b0;
    start_dl(8'd2);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(8'hA0 + i));
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait_occ2 got=%b exp=0", ioctl_wait); end
    for (int i = 4; i < 6; i++) wr_byte(25'(i), 8'(8'hA0 + i));
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL bp_wait_occ3 got=%b exp=1", ioctl_wait); end
    for (int i = 6; i < 8; i++) wr_byte(25'(i), 8'(8'hA0 + i));
    tick(10);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_no_overflow got=%b exp=0", overflow); end
    total++; if (log_n !== 0) begin bad++; $display("FAIL bp_held_off got=%0d exp=0", log_n); end
    ack_en = 1'b1;
    end_dl();
    tick(30);
    total++; if (log_n !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", log_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (log_addr[i] !== 25'(2 * i) || log_din[i] !== {8'(8'hA1 + 2 * i), 8'(8'hA0 + 2 * i)}) begin bad++; $display("FAIL bp_word%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_din[i], 25'(2 * i), {8'(8'hA1 + 2 * i), 8'(8'hA0 + 2 * i)}); end
    end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait_done got=%b exp=0", ioctl_wait); end
  endtask

  task automatic test_overflow();
    log_n = 0; ack_en = 1'b0;
    start_dl(8'd2);
    for (int i = 0; i < 12; i++) wr_byte(25'(i), 8'(8'h50 + i));
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL ovf_wait got=%b exp=1", ioctl_wait); end
    ack_en = 1'b1;
    end_dl();
    tick(30);
    total++; if (log_n !== 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", log_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (log_addr[i] !== 25'(2 * i) || log_din[i] !== {8'(8'h51 + 2 * i), 8'(8'h50 + 2 * i)}) begin bad++; $display("FAIL ovf_word%0d got=%h/%h", i, log_addr[i], log_din[i]); end
    end
    total++; if (word_count !== 24'd4) begin bad++; $display("FAIL ovf_word_count got=%0d exp=4", word_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_other_index();
    we_cycles = 0;
    start_dl(8'd1);
    wr_byte(25'd0, 8'h99);
    wr_byte(25'd1, 8'h88);
    end_dl();
    tick(10);
    total++; if (we_cycles !== 0) begin bad++; $display("FAIL idx1_mem_we got=%0d exp=0", we_cycles); end
    total++; if (overlay_valid !== 1'b1) begin bad++; $display("FAIL idx1_valid got=%b exp=1", overlay_valid); end
    total++; if (word_count !== 24'd4) begin bad++; $display("FAIL idx1_word_count got=%0d exp=4", word_count); end
  endtask

  task automatic test_pending();
    logic [24:0] ea [3];
    logic [15:0] ed [3];
    ea = '{25'd2, 25'd6, 25'd8};
    ed = '{16'hBB00, 16'hFFEE, 16'h00CC};
    log_n = 0; ack_en = 1'b1; ack_delay = 1;
    start_dl(8'd2);
    wr_byte(25'd0, 8'hAA);
    wr_byte(25'd3, 8'hBB);
    wr_byte(25'd6, 8'hDD);
    wr_byte(25'd6, 8'hEE);
    wr_byte(25'd7, 8'hFF);
    wr_byte(25'd8, 8'hCC);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pend_overflow_cleared got=%b exp=0", overflow); end
    end_dl();
    tick(20);
    total++; if (log_n !== 3) begin bad++; $display("FAIL pend_count got=%0d exp=3", log_n); end
    for (int i = 0; i < 3; i++) begin
      total++; if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin bad++; $display("FAIL pend_word%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_din[i], ea[i], ed[i]); end
    end
    total++; if (overlay_valid !== 1'b1) begin bad++; $display("FAIL pend_valid got=%b exp=1", overlay_valid); end
  endtask

  task automatic test_restart();
    log_n = 0; ack_en = 1'b0;
    start_dl(8'd2);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(8'h60 + i));
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_dl_req got=%b exp=1", mem_we); end
    end_dl();
    start_dl(8'd2);
    @(negedge clk_sys);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_dl_abandon got=%b exp=0", mem_we); end
    ack_en = 1'b1;
    wr_byte(25'd10, 8'h01);
    wr_byte(25'd11, 8'h02);
    end_dl();
    tick(20);
    total++; if (log_n !== 1) begin bad++; $display("FAIL rst_dl_count got=%0d exp=1", log_n); end
    total++; if (log_addr[0] !== 25'd10 || log_din[0] !== 16'h0201) begin bad++; $display("FAIL rst_dl_word got=%h/%h exp=a/0201", log_addr[0], log_din[0]); end
    total++; if (word_count !== 24'd1) begin bad++; $display("FAIL rst_dl_word_count got=%0d exp=1", word_count); end
  endtask

  task automatic test_reset_drain();
    log_n = 0; ack_en = 1'b0;
    start_dl(8'd2);
    for (int i = 0; i < 4; i++) wr_byte(25'(8'h20 + i), 8'(8'h70 + i));
    end_dl();
    tick(3);
    total++; if (mem_we !== 1'b1 || mem_addr !== 25'h20) begin bad++; $display("FAIL drain_req got=%b/%h exp=1/20", mem_we, mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL drain_rst_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 25'd0 || mem_din !== 16'd0) begin bad++; $display("FAIL drain_rst_mem got=%h/%h exp=0/0", mem_addr, mem_din); end
    total++; if ({ioctl_wait, overlay_valid, overflow} !== 3'b000 || word_count !== 24'd0) begin bad++; $display("FAIL drain_rst_flags got=%b/%0d exp=000/0", {ioctl_wait, overlay_valid, overflow}, word_count); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    we_cycles = 0;
    ack_en = 1'b1;
    tick(20);
    total++; if (we_cycles !== 0) begin bad++; $display("FAIL drain_post_release got=%0d exp=0", we_cycles); end
    total++; if (log_n !== 0) begin bad++; $display("FAIL drain_post_log got=%0d exp=0", log_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_five();
    test_backpressure();
    test_overflow();
    test_other_index();
    test_pending();
    test_restart();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
